// File: rtl/div_fixed_point.sv
// Sequential signed fixed-point divider (restoring, one quotient bit per cycle) with N/V/Z flags.
// Optional round-to-nearest (ties away from zero) when DIV_FP_ROUND_EN is defined; truncates otherwise.
module div_fixed_point #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = DATA_WIDTH / 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Out,
    output logic                  N,
    output logic                  V,
    output logic                  Z
);

    localparam int ITER = DATA_WIDTH + FRAC_BITS;
    localparam int CW   = $clog2(ITER + 1);
    localparam int RW   = DATA_WIDTH + 1;

    localparam logic [ITER:0] POS_LIM = {{(ITER - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [ITER:0] NEG_LIM = {{(ITER - DATA_WIDTH + 1){1'b0}}, 1'b1, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] SAT_POS = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_NEG = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ONE_W   = {{(DATA_WIDTH - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Unsigned magnitude; the most negative code maps to 2^(DATA_WIDTH-1).
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] x);
        if (x[DATA_WIDTH-1]) begin
            magnitude = ~x + ONE_W;
        end else begin
            magnitude = x;
        end
    endfunction

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ITER-1:0]       dvd_q, dvd_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [ITER-1:0]       quo_q, quo_d;
    logic                  neg_q, neg_d;
    logic                  dvz_q, dvz_d;
    logic                  aneg_q, aneg_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  v_q, v_d;
    logic                  n_q, n_d;
    logic                  z_q, z_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [RW-1:0]         rem_shift_s;
    logic                  qbit_s;
    logic [RW-1:0]         rem_next_s;
    logic [ITER-1:0]       quo_next_s;
    logic [ITER:0]         qfinal_s;
    logic [DATA_WIDTH-1:0] qlow_s;
    logic                  last_s;
    logic [DATA_WIDTH-1:0] res_s;
    logic                  res_v_s;

    // One restoring step: bring down the next dividend bit and subtract the divisor if it fits.
    always_comb begin
        rem_shift_s = {rem_q, dvd_q[ITER-1]};
        qbit_s      = (rem_shift_s >= {1'b0, dvs_q});
        if (qbit_s) begin
            rem_next_s = rem_shift_s - {1'b0, dvs_q};
        end else begin
            rem_next_s = rem_shift_s;
        end
        quo_next_s = ITER'({quo_q, qbit_s});
        qfinal_s   = {1'b0, quo_next_s};
`ifdef DIV_FP_ROUND_EN
        if ({rem_next_s, 1'b0} >= {2'b00, dvs_q}) begin
            qfinal_s = qfinal_s + {{ITER{1'b0}}, 1'b1};
        end else begin
            qfinal_s = qfinal_s;
        end
`endif
        qlow_s = qfinal_s[DATA_WIDTH-1:0];
    end

    // Signed result with saturation and divide-by-zero override.
    always_comb begin
        res_s   = '0;
        res_v_s = 1'b0;
        if (dvz_q) begin
            res_s   = aneg_q ? SAT_NEG : SAT_POS;
            res_v_s = 1'b1;
        end else if (!neg_q) begin
            if (qfinal_s > POS_LIM) begin
                res_s   = SAT_POS;
                res_v_s = 1'b1;
            end else begin
                res_s   = qlow_s;
                res_v_s = 1'b0;
            end
        end else begin
            if (qfinal_s > NEG_LIM) begin
                res_s   = SAT_NEG;
                res_v_s = 1'b1;
            end else begin
                res_s   = ~qlow_s + ONE_W;
                res_v_s = 1'b0;
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        neg_d   = neg_q;
        dvz_d   = dvz_q;
        aneg_d  = aneg_q;
        out_d   = out_q;
        v_d     = v_q;
        n_d     = n_q;
        z_d     = z_q;
        last_s  = (cnt_q == CW'(ITER - 1));
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    dvd_d   = {magnitude(A), {FRAC_BITS{1'b0}}};
                    dvs_d   = magnitude(B);
                    rem_d   = '0;
                    quo_d   = '0;
                    neg_d   = A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1];
                    dvz_d   = (B == '0);
                    aneg_d  = A[DATA_WIDTH-1];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + {{(CW - 1){1'b0}}, 1'b1};
                dvd_d = {dvd_q[ITER-2:0], 1'b0};
                rem_d = DATA_WIDTH'(rem_next_s);
                quo_d = quo_next_s;
                if (last_s) begin
                    state_d = S_DONE;
                    out_d   = res_s;
                    v_d     = res_v_s;
                    n_d     = res_s[DATA_WIDTH-1];
                    z_d     = (res_s == '0);
                end else begin
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            neg_q   <= 1'b0;
            dvz_q   <= 1'b0;
            aneg_q  <= 1'b0;
            out_q   <= '0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            neg_q   <= neg_d;
            dvz_q   <= dvz_d;
            aneg_q  <= aneg_d;
            out_q   <= out_d;
            v_q     <= v_d;
            n_q     <= n_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Out  = out_q;
    assign N    = n_q;
    assign V    = v_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_div_fixed_point.sv
// Self-checking bench for div_fixed_point: directed corner cases plus random operands
// compared against an integer-arithmetic reference model.
module tb_div_fixed_point;

    localparam int DW   = 16;
    localparam int FB   = 8;
    localparam int ITER = DW + FB;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          busy;
    logic          done;
    logic [DW-1:0] Out;
    logic          N;
    logic          V;
    logic          Z;

    int checks = 0;
    int errors = 0;

    div_fixed_point #(.DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .Out  (Out),
        .N    (N),
        .V    (V),
        .Z    (Z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer division of the scaled magnitudes, then sign and clamp.
    function automatic void model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  output logic [DW-1:0] o, output logic v);
        longint sa, sb, ma, mb, q, r, nq;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            o = (sa < 0) ? 16'h8000 : 16'h7FFF;
            v = 1'b1;
            return;
        end
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        q  = (ma * (64'sd1 <<< FB)) / mb;
        r  = (ma * (64'sd1 <<< FB)) % mb;
`ifdef DIV_FP_ROUND_EN
        if (2 * r >= mb) q = q + 1;
`else
        if (r < 0) q = 0;
`endif
        if ((sa < 0) == (sb < 0)) begin
            if (q > 32767) begin o = 16'h7FFF; v = 1'b1; end
            else begin o = q[DW-1:0]; v = 1'b0; end
        end else begin
            if (q > 32768) begin o = 16'h8000; v = 1'b1; end
            else begin nq = -q; o = nq[DW-1:0]; v = 1'b0; end
        end
    endfunction

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit disturb);
        logic [DW-1:0] eo;
        logic          ev;
        int            n;
        bit            seen;
        bit            busy_bad;
        model(a, b, eo, ev);
        @(posedge clk);
        #1 A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; seen = 1'b0; busy_bad = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) busy_bad = 1'b1;
                if (disturb && n == 5) begin
                    A = ~A; B = 16'($urandom); start = 1'b1;
                end
                if (disturb && n == 6) start = 1'b0;
            end
        end
        check($sformatf("latency a=%h b=%h", a, b), n, ITER + 1);
        check("busy_during_op", {busy_bad, busy}, {1'b0, 1'b1});
        check($sformatf("Out a=%h b=%h", a, b), Out, eo);
        check($sformatf("V a=%h b=%h", a, b), V, ev);
        check($sformatf("N a=%h b=%h", a, b), N, eo[DW-1]);
        check($sformatf("Z a=%h b=%h", a, b), Z, (eo == '0));
        @(negedge clk);
        check("after_done busy/done", {busy, done}, 2'b00);
    endtask

    initial begin
        int cyc;
        int ndone;
        int t[$];
        logic [DW-1:0] ra, rb;

        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy/done", {busy, done}, 2'b00);
        check("reset Out", Out, 16'h0000);
        check("reset NVZ", {N, V, Z}, 3'b001);

        run_op(16'h0300, 16'h0200, 1'b0);
        run_op(16'hFD00, 16'h0200, 1'b0);
        run_op(16'h0200, 16'h0300, 1'b0);
        run_op(16'h7F00, 16'h0080, 1'b0);
        run_op(16'h8000, 16'hFF00, 1'b0);
        run_op(16'h8000, 16'h0100, 1'b0);
        run_op(16'h0100, 16'h0000, 1'b0);
        run_op(16'hFF00, 16'h0000, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b0);
        run_op(16'h0000, 16'h0500, 1'b0);
        run_op(16'h0A40, 16'hFE20, 1'b1);

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 3 == 0) rb = {{8{rb[15]}}, rb[7:0]};
            run_op(ra, rb, (i % 5 == 0));
        end

        // Abort in the tenth CALC cycle; previous Out (from 0x0300/0x0200) is nonzero.
        run_op(16'h0300, 16'h0200, 1'b0);
        @(posedge clk);
        #1 A = 16'h1234; B = 16'h0100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort busy/done", {busy, done}, 2'b00);
        check("abort Out", Out, 16'h0000);
        check("abort NVZ", {N, V, Z}, 3'b001);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort no done", ndone, 0);
        run_op(16'hFA00, 16'h0300, 1'b0);

        // start held high: one accept per idle cycle, a result every ITER+2 cycles.
        @(posedge clk);
        #1 A = 16'h0300; B = 16'h0200; start = 1'b1;
        cyc = 0;
        while (t.size() < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                t.push_back(cyc);
                check("b2b Out", Out, 16'h0180);
            end
        end
        start = 1'b0;
        check("b2b pulses", t.size(), 3);
        if (t.size() == 3) begin
            check("b2b first", t[0], ITER + 2);
            check("b2b gap1", t[1] - t[0], ITER + 2);
            check("b2b gap2", t[2] - t[1], ITER + 2);
        end
        repeat (4) @(negedge clk);
        check("b2b idle", {busy, done}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
